// File: rtl/bus_master_if_pkg.sv
// Shared definitions for the bus master interface: state encodings,
// direction and active-low strobe levels, default SPM window.
package bus_master_if_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REQ    = 2'b01,
    ACCESS = 2'b10,
    STALL  = 2'b11
  } state_e;

  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam logic [31:0] SPM_BASE_DEF = 32'h2000_0000;
  localparam int unsigned SPM_AW_DEF   = 14;

endpackage

// File: rtl/bus_master_if_addr_dec.sv
// bus_addr_dec: combinational SPM-window hit decode. Takes only the tag
// (address bits above the window) so it can be shared with other decoders.
module bus_addr_dec
  import bus_master_if_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] SPM_BASE = ADDR_W'(SPM_BASE_DEF),
  parameter int unsigned       SPM_AW   = SPM_AW_DEF
) (
  input  logic [ADDR_W-SPM_AW-1:0] tag,
  output logic                     hit
);

  localparam logic [ADDR_W-SPM_AW-1:0] BASE_TAG = SPM_BASE[ADDR_W-1:SPM_AW];

  assign hit = (tag == BASE_TAG);

endmodule

// File: rtl/bus_master_if.sv
// bus_master_if: pipeline-stage memory access unit. Accesses hitting the
// SPM window complete combinationally; everything else goes through
// request/grant arbitration on the shared bus, then waits for ready.
// Optional macro BUS_TIMEOUT_EN adds an ACCESS wait timeout with err pulse.
module bus_master_if
  import bus_master_if_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] SPM_BASE = ADDR_W'(SPM_BASE_DEF),
  parameter int unsigned       SPM_AW   = SPM_AW_DEF,
  parameter int unsigned       TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                as_,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                rw,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W-1:0]   rd_data,
  output logic                busy,
  output logic                err,
  input  logic [DATA_W-1:0]   spm_rd_data,
  output logic [SPM_AW-1:0]   spm_addr,
  output logic                spm_as_,
  output logic                spm_rw,
  output logic [DATA_W/8-1:0] spm_be,
  output logic [DATA_W-1:0]   spm_wr_data,
  input  logic [DATA_W-1:0]   bus_rd_data,
  input  logic                bus_rdy_,
  input  logic                bus_grnt_,
  output logic                bus_req_,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic                bus_as_,
  output logic                bus_rw,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [DATA_W-1:0]   bus_wr_data
);

  state_e            state, next_state;
  logic              spm_hit;
  logic              spm_sel;
  logic              launch;
  logic              grant;
  logic              done;
  logic              drop;
  logic              timeout;
  logic              to_hit;
  logic [DATA_W-1:0] rd_q;

  bus_addr_dec #(
    .ADDR_W  (ADDR_W),
    .SPM_BASE(SPM_BASE),
    .SPM_AW  (SPM_AW)
  ) u_addr_dec (
    .tag(addr[ADDR_W-1:SPM_AW]),
    .hit(spm_hit)
  );

  assign spm_addr    = addr[SPM_AW-1:0];
  assign spm_rw      = rw;
  assign spm_be      = be;
  assign spm_wr_data = wr_data;
  assign rd_data     = spm_sel ? spm_rd_data : rd_q;

`ifdef BUS_TIMEOUT_EN
  logic [15:0] wait_cnt;

  // ACCESS wait counter: cleared on grant, counts cycles without ready
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (grant) begin
      wait_cnt <= '0;
    end else if (state == ACCESS && bus_rdy_ == DISABLE_) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  // Fires in the ACCESS cycle whose missing ready would bring the count to TIMEOUT
  assign to_hit = (wait_cnt == 16'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^16'(TIMEOUT);
  assign to_hit         = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decode, stage handshake and transfer events
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    err        = 1'b0;
    spm_sel    = 1'b0;
    launch     = 1'b0;
    grant      = 1'b0;
    done       = 1'b0;
    drop       = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (as_ == ENABLE_ && !flush) begin
          if (spm_hit) begin
            spm_sel = 1'b1;
          end else begin
            launch     = 1'b1;
            busy       = 1'b1;
            next_state = REQ;
          end
        end
      end
      REQ: begin
        busy = 1'b1;
        if (flush) begin
          drop       = 1'b1;
          next_state = IDLE;
        end else if (bus_grnt_ == ENABLE_) begin
          grant      = 1'b1;
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        busy = 1'b1;
        // Ready takes priority over a timeout landing in the same cycle
        if (bus_rdy_ == ENABLE_) begin
          done = 1'b1;
        end else if (to_hit) begin
          timeout = 1'b1;
          err     = 1'b1;
        end
        if (done || timeout) begin
          busy       = 1'b0;
          next_state = stall ? STALL : IDLE;
        end
      end
      STALL: begin
        if (!stall) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    spm_as_ = spm_sel ? ENABLE_ : DISABLE_;
  end

  // Bus-side registers and read data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_req_    <= DISABLE_;
      bus_as_     <= DISABLE_;
      bus_rw      <= READ;
      bus_addr    <= '0;
      bus_be      <= '0;
      bus_wr_data <= '0;
      rd_q        <= '0;
    end else begin
      bus_as_ <= grant ? ENABLE_ : DISABLE_;
      if (launch) begin
        bus_req_    <= ENABLE_;
        bus_addr    <= addr;
        bus_rw      <= rw;
        bus_be      <= be;
        bus_wr_data <= wr_data;
      end
      if (drop || done || timeout) bus_req_ <= DISABLE_;
      if (done && bus_rw != WRITE) rd_q <= bus_rd_data;
      if (timeout) rd_q <= '1;
    end
  end

endmodule

// File: tb/tb_bus_master_if.sv
// Testbench for bus_master_if: decode vector table, directed multi-cycle
// sequences and randomized transactions against a transaction-level model.
module tb_bus_master_if;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset, stall, flush, as_, rw;
  logic [31:0] addr, wr_data, rd_data, spm_rd_data, spm_wr_data;
  logic [3:0]  be, spm_be, bus_be;
  logic        busy, err, spm_as_, spm_rw;
  logic [13:0] spm_addr;
  logic [31:0] bus_rd_data, bus_addr, bus_wr_data;
  logic        bus_rdy_, bus_grnt_, bus_req_, bus_as_, bus_rw;

  int          nchecks = 0;
  int          nerr = 0;
  logic [31:0] model_rd;

  always #5 clk = ~clk;

  bus_master_if #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .SPM_BASE(32'h2000_0000),
    .SPM_AW  (14),
    .TIMEOUT (TO)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .as_(as_),
    .addr(addr), .rw(rw), .be(be), .wr_data(wr_data), .rd_data(rd_data),
    .busy(busy), .err(err), .spm_rd_data(spm_rd_data), .spm_addr(spm_addr),
    .spm_as_(spm_as_), .spm_rw(spm_rw), .spm_be(spm_be),
    .spm_wr_data(spm_wr_data), .bus_rd_data(bus_rd_data),
    .bus_rdy_(bus_rdy_), .bus_grnt_(bus_grnt_), .bus_req_(bus_req_),
    .bus_addr(bus_addr), .bus_as_(bus_as_), .bus_rw(bus_rw),
    .bus_be(bus_be), .bus_wr_data(bus_wr_data)
  );

  typedef struct {
    logic [31:0] a;
    logic        as_n;
    logic        fl;
    logic [31:0] d;
    logic        e_spm_as;
    logic        e_busy;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One SPM access (single cycle), then one idle cycle
  task automatic do_spm(input logic [31:0] a, input logic [31:0] d, input logic r_w);
    tick();
    as_ = 1'b0; addr = a; rw = r_w; be = 4'hF; wr_data = ~d;
    spm_rd_data = d; flush = 1'b0; stall = 1'b0;
    @(negedge clk);
    chk("spm_as", spm_as_, 1'b0);
    chk("spm_busy", busy, 1'b0);
    chk("spm_rd", rd_data, d);
    chk("spm_req", bus_req_, 1'b1);
    chk("spm_addr", spm_addr, a[13:0]);
    chk("spm_rw", spm_rw, r_w);
    chk("spm_wd", spm_wr_data, ~d);
    tick();
    as_ = 1'b1;
    @(negedge clk);
    chk("spm_after_rd", rd_data, model_rd);
    chk("spm_after_as", spm_as_, 1'b1);
  endtask

  // One bus transaction: grant after g REQ cycles, ready r cycles after the
  // strobe (r<0: never), stall held for st cycles from completion.
  task automatic do_bus(input logic [31:0] a, input logic r_w, input logic [3:0] b,
                        input logic [31:0] wd, input int g, input int r,
                        input logic [31:0] rdv, input int st);
    int          busy_n, as_cnt, err_n, req_seen, acc, cyc;
    logic        started, done, to;
    logic [31:0] exp_rd;
    busy_n = 0; as_cnt = 0; err_n = 0; req_seen = 0; acc = 0; cyc = 0;
    started = 1'b0; done = 1'b0;
    to = (r < 0);
    exp_rd = to ? 32'hFFFF_FFFF : (r_w ? rdv : model_rd);
    while (!done && cyc < 200) begin
      tick();
      if (cyc == 0) begin
        as_ = 1'b0; addr = a; rw = r_w; be = b; wr_data = wd;
        bus_rd_data = rdv; stall = (st > 0); flush = 1'b0;
      end
      if (!bus_as_) started = 1'b1;
      bus_grnt_ = !(!bus_req_ && req_seen >= g);
      bus_rdy_  = !(started && !to && acc >= r);
      @(negedge clk);
      if (busy) busy_n++;
      else done = 1'b1;
      if (!bus_as_) begin
        as_cnt++;
        chk("bus_addr", bus_addr, a);
        chk("bus_rw", bus_rw, r_w);
        chk("bus_be", bus_be, b);
        chk("bus_wd", bus_wr_data, wd);
      end
      if (err) err_n++;
      if (!bus_req_) req_seen++;
      if (started) acc++;
      cyc++;
    end
    if (!done) begin
      nchecks++;
      nerr++;
      $display("FAIL bus_done: busy still 1 after %0d cycles, want 0", cyc);
    end
    chk("busy_cycles", busy_n, to ? 2 + g + TO - 1 : 2 + g + r);
    chk("bus_as_pulses", as_cnt, 1);
    chk("err_pulses", err_n, to ? 1 : 0);
    model_rd = exp_rd;
    for (int k = 0; k < st; k++) begin
      tick();
      bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
      if (k < st - 1) begin
        as_ = 1'b0; addr = 32'h0000_0100; stall = 1'b1;
      end else begin
        as_ = 1'b1; stall = 1'b0;
      end
      @(negedge clk);
      chk("stall_busy", busy, 1'b0);
      chk("stall_req", bus_req_, 1'b1);
      chk("stall_rd", rd_data, model_rd);
    end
    tick();
    as_ = 1'b1; stall = 1'b0; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
    @(negedge clk);
    chk("post_rd", rd_data, model_rd);
    chk("post_req", bus_req_, 1'b1);
    chk("post_busy", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; as_ = 1'b1; addr = '0; rw = 1'b1;
    be = '0; wr_data = '0; spm_rd_data = '0; bus_rd_data = '0;
    bus_rdy_ = 1'b1; bus_grnt_ = 1'b1; model_rd = '0;

    vt[0] = '{32'h2000_0004, 1'b0, 1'b0, 32'hCAFE_0001, 1'b0, 1'b0, 32'hCAFE_0001};
    vt[1] = '{32'h2000_3FFF, 1'b0, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0BAD_F00D};
    vt[2] = '{32'h2000_4000, 1'b0, 1'b1, 32'h1111_1111, 1'b1, 1'b0, 32'h0};
    vt[3] = '{32'h1FFF_FFFC, 1'b0, 1'b1, 32'h2222_2222, 1'b1, 1'b0, 32'h0};
    vt[4] = '{32'h2000_0008, 1'b0, 1'b0, 32'h3333_3333, 1'b0, 1'b0, 32'h3333_3333};
    vt[5] = '{32'h0000_0100, 1'b1, 1'b0, 32'h4444_4444, 1'b1, 1'b0, 32'h0};

    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_req", bus_req_, 1'b1);
    chk("rst_as", bus_as_, 1'b1);
    chk("rst_rw", bus_rw, 1'b1);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_be", bus_be, 4'h0);
    chk("rst_wd", bus_wr_data, 32'h0);
    chk("rst_rd", rd_data, 32'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);

    // Decode table, all from IDLE with no access launched
    for (int i = 0; i < 6; i++) begin
      tick();
      as_ = vt[i].as_n; addr = vt[i].a; flush = vt[i].fl; rw = 1'b1;
      spm_rd_data = vt[i].d;
      @(negedge clk);
      chk("vec_spm_as", spm_as_, vt[i].e_spm_as);
      chk("vec_busy", busy, vt[i].e_busy);
      chk("vec_rd", rd_data, vt[i].e_rd);
      chk("vec_req", bus_req_, 1'b1);
    end
    tick();
    as_ = 1'b1; flush = 1'b0;

    do_spm(32'h2000_0004, 32'hCAFE_0001, 1'b1);
    do_bus(32'h0000_0100, 1'b1, 4'hF, 32'h0, 1, 1, 32'h1234_5678, 0);
    do_bus(32'h0000_0200, 1'b0, 4'b0011, 32'hAAAA_5555, 0, 0, 32'hDEAD_DEAD, 0);
    do_bus(32'h0000_0300, 1'b1, 4'hF, 32'h0, 0, 2, 32'h0000_BEEF, 3);

    // Flush while waiting for grant drops the request without a strobe
    tick();
    as_ = 1'b0; addr = 32'h0000_0400; rw = 1'b1; flush = 1'b0; bus_grnt_ = 1'b1;
    @(negedge clk);
    chk("fl_launch_busy", busy, 1'b1);
    tick();
    as_ = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("fl_req_low", bus_req_, 1'b0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("fl_req_rel", bus_req_, 1'b1);
    chk("fl_as", bus_as_, 1'b1);
    chk("fl_busy", busy, 1'b0);
    tick();
    @(negedge clk);
    chk("fl_as_late", bus_as_, 1'b1);

`ifdef BUS_TIMEOUT_EN
    do_bus(32'h0000_0500, 1'b1, 4'hF, 32'h0, 0, -1, 32'h5555_0000, 0);
    do_bus(32'h0000_0504, 1'b1, 4'hF, 32'h0, 0, TO - 1, 32'h5555_0001, 0);
`endif

    // Reset in the middle of ACCESS
    tick();
    as_ = 1'b0; addr = 32'h0000_0600; rw = 1'b0; be = 4'hC; wr_data = 32'h7777_8888;
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
    tick();
    bus_grnt_ = 1'b0;
    tick();
    @(negedge clk);
    chk("mid_as", bus_as_, 1'b0);
    tick();
    reset = 1'b1; as_ = 1'b1; bus_grnt_ = 1'b1;
    tick();
    @(negedge clk);
    chk("mrst_req", bus_req_, 1'b1);
    chk("mrst_as", bus_as_, 1'b1);
    chk("mrst_rw", bus_rw, 1'b1);
    chk("mrst_addr", bus_addr, 32'h0);
    chk("mrst_be", bus_be, 4'h0);
    chk("mrst_wd", bus_wr_data, 32'h0);
    chk("mrst_rd", rd_data, 32'h0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_err", err, 1'b0);
    tick();
    reset = 1'b0;
    model_rd = '0;

    // Randomized mix against the transaction model
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_spm(32'h2000_0000 | ($urandom() & 32'h0000_3FFF), $urandom(), 1'($urandom_range(0, 1)));
      end else begin
        ra = $urandom();
        if ((ra >> 14) == (32'h2000_0000 >> 14)) ra = ra ^ 32'h8000_0000;
        do_bus(ra, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom(),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom(),
               int'($urandom_range(0, 3)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/bus_master_if.md
Name: bus_master_if

Overview:
- Parametrised pipeline-stage memory access unit; one instance per access stage (IF fetch, MEM load/store).
- Decodes each access to either the dual-port SPM (zero wait) or the shared system bus (request/grant arbitration, then wait-for-ready).
- Generalises the fixed 32-bit IF/MEM bus ports to configurable address/data width, SPM window and byte enables.
- Adds bus-error reporting.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits; must be a multiple of 8.
- SPM_BASE, 32'h2000_0000, base address of the SPM window; aligned to 2^SPM_AW.
- SPM_AW, 14, log2 of SPM window size in bytes.
- TIMEOUT, 255, maximum wait cycles in ACCESS before an error. Used only with BUS_TIMEOUT_EN; range 1..2^16-1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- stall  in  1  stage stall from cpu_ctrl
- flush  in  1  stage flush from cpu_ctrl
- as_  in  1  access strobe from stage, active low
- addr  in  ADDR_W  byte address
- rw  in  1  1=read, 0=write
- be  in  DATA_W/8  byte enables for writes
- wr_data  in  DATA_W  write data
- rd_data  out  DATA_W  read data to stage
- busy  out  1  stage must stall
- err  out  1  one-cycle bus error pulse
- spm_rd_data  in  DATA_W  SPM read data
- spm_addr  out  SPM_AW  SPM byte address
- spm_as_  out  1  SPM strobe
- spm_rw  out  1  SPM direction
- spm_be  out  DATA_W/8  SPM byte enables
- spm_wr_data  out  DATA_W  SPM write data
- bus_rd_data  in  DATA_W  bus read data
- bus_rdy_  in  1  bus ready, active low
- bus_grnt_  in  1  bus grant, active low
- bus_req_  out  1  bus request, active low
- bus_addr  out  ADDR_W  bus address
- bus_as_  out  1  bus strobe, active low
- bus_rw  out  1  bus direction
- bus_be  out  DATA_W/8  bus byte enables
- bus_wr_data  out  DATA_W  bus write data

Behaviour:

SPM hit and path:
- spm_hit = (addr[ADDR_W-1:SPM_AW] == SPM_BASE[ADDR_W-1:SPM_AW]).
- spm_addr, spm_rw, spm_be and spm_wr_data are combinational copies of the stage inputs.
- spm_as_ = 0 only when state==IDLE && !as_ && spm_hit && !flush.
- For an SPM hit in IDLE: rd_data = spm_rd_data (combinational), busy = 0. The SPM has zero wait.

State machine: IDLE, REQ, ACCESS, STALL (2-bit encoding).
- IDLE:
  - If !as_ && !spm_hit && !flush: bus_req_<=0; latch addr/rw/be/wr_data into bus_addr/bus_rw/bus_be/bus_wr_data; go to REQ. busy=1 combinationally in that cycle.
  - flush suppresses any new access.
- REQ:
  - busy=1.
  - When bus_grnt_==0: bus_as_<=0 for exactly one cycle; go to ACCESS.
  - A flush while in REQ drops the request: bus_req_<=1, return to IDLE.
- ACCESS:
  - bus_as_=1. busy=1 until bus_rdy_ is seen.
  - On bus_rdy_==0: latch rd_data <= bus_rd_data (reads only; writes leave rd_data unchanged); bus_req_<=1; busy=0 in that same cycle; next state = stall ? STALL : IDLE.
  - flush is ignored in ACCESS; the transfer always completes.
- STALL:
  - busy=0; rd_data held.
  - Go to IDLE when stall==0.
  - A new as_ is not accepted until IDLE.

Reset:
- Reset values: state=IDLE, bus_req_=1, bus_as_=1, bus_rw=1, bus_addr=0, bus_be=0, bus_wr_data=0, rd_data=0, err=0.
- Reset in any state aborts immediately; the bus is released within one cycle.

Boundaries and latency:
- Bus grant held by another master: remain in REQ indefinitely (absent timeout).
- Address exactly SPM_BASE+2^SPM_AW-1 is a hit; SPM_BASE+2^SPM_AW is a miss.
- Minimum bus latency: 3 cycles (IDLE→REQ→ACCESS with rdy_ on the first ACCESS cycle).

Optional Feature:
- Macro BUS_TIMEOUT_EN.
- Defined:
  - A 16-bit wait counter clears on entry to ACCESS and increments each ACCESS cycle without bus_rdy_.
  - When it reaches TIMEOUT: err=1 for one cycle, rd_data<=all ones, bus_req_<=1, busy=0, next state as on a normal completion.
  - A rdy_ arriving in the same cycle as timeout wins; no err.
- Undefined:
  - No counter; err is tied to 0; ACCESS waits indefinitely.

Decomposition:
- Shared package/header (bus_head): state encodings, READ=1/WRITE=0, ENABLE_=0/DISABLE_=1, default SPM_BASE/SPM_AW.
- One natural sub-module, bus_addr_dec: purely combinational SPM-window hit decode, reusable by the bus arbiter's decoder.

Test Plan:
- SPM read at addr=SPM_BASE+4 with spm_rd_data=32'hCAFE_0001 → spm_as_=0, rd_data=32'hCAFE_0001, busy=0 in the same cycle, bus_req_ stays 1.
- Bus read at 32'h0000_0100, grant after 2 cycles, rdy_ 1 cycle after as_, bus_rd_data=32'h1234_5678 → bus_as_ pulses exactly 1 cycle; busy=1 for 4 cycles then 0; rd_data=32'h1234_5678; bus_req_ returns to 1.
- Bus write be=4'b0011, wr_data=32'hAAAA_5555 → bus_rw=0, bus_be=4'b0011, bus_wr_data=32'hAAAA_5555 during as_; rd_data unchanged.
- Completion with stall=1 held for 3 cycles → state STALL; rd_data held; busy=0; new as_ ignored until stall drops.
- Flush in REQ → bus_req_=1 next cycle, IDLE, no bus_as_ pulse.
- BUS_TIMEOUT_EN with TIMEOUT=4 and rdy_ never asserted → err=1 exactly once on the 4th ACCESS cycle; rd_data=32'hFFFF_FFFF; bus_req_=1.
- Reset asserted mid-ACCESS → all outputs at reset values next cycle.
